// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and FSM state types
// for the CSR counter reader.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [4:0] OFF_CYCLE_LO   = 5'h00;
  localparam logic [4:0] OFF_CYCLE_HI   = 5'h04;
  localparam logic [4:0] OFF_INSTRET_LO = 5'h08;
  localparam logic [4:0] OFF_INSTRET_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL       = 5'h10;

  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;

endpackage

// File: rtl/csr_counter_axil_reader_if.sv
// AXI4-Lite bus bundle with master/slave views.
// Channel names follow the AMBA signal names.
interface csr_counter_axil_reader_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    output AWADDR, AWVALID,
    output WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    input  AWADDR, AWVALID,
    input  WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/cnt_hi_shadow.sv
// Upper-half shadow of a 64-bit counter: sampled on a LO
// read so {HI,LO} is coherent; bypassed when snapping is off.
module cnt_hi_shadow (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [63:0] cnt,
  input  logic        latch_en,
  input  logic        snap_en,
  output logic [31:0] hi_out
);

  logic [31:0] shadow_hi;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      shadow_hi <= '0;
    else if (latch_en && snap_en)
      shadow_hi <= cnt[63:32];
  end

  assign hi_out = snap_en ? shadow_hi : cnt[63:32];

  logic unused_lo;
  assign unused_lo = &{1'b0, cnt[31:0]};

endmodule

// File: rtl/csr_counter_axil_reader.sv
// AXI4-Lite slave exposing 64-bit cycle/instret counters
// as 32-bit LO/HI registers plus a SNAP_EN control bit.
module csr_counter_axil_reader
  import axil_pkg::*;
#(
  parameter int   ADDR_W   = 32,
  parameter logic CTRL_RST = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [63:0] cycle_cnt,
  input  logic [63:0] instret_cnt,
  csr_counter_axil_reader_if.slave bus
);

  r_state_e rs, rs_nxt;
  w_state_e ws, ws_nxt;

  logic              snap_en;
  logic [ADDR_W-1:0] araddr;
  logic [ADDR_W-1:0] awaddr;
  logic [4:0]        ar_off;
  logic              ar_hs;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [31:0]       cyc_hi;
  logic [31:0]       ins_hi;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  assign araddr = bus.ARADDR;
  assign awaddr = bus.AWADDR;
  assign ar_off = araddr[4:0];

  assign bus.ARREADY = (rs == R_IDLE);
  assign bus.RVALID  = (rs == R_RESP);
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign ar_hs       = bus.ARVALID && (rs == R_IDLE);

  cnt_hi_shadow u_cyc_shadow (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .cnt      (cycle_cnt),
    .latch_en (ar_hs && ar_off == OFF_CYCLE_LO),
    .snap_en  (snap_en),
    .hi_out   (cyc_hi)
  );

  cnt_hi_shadow u_ins_shadow (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .cnt      (instret_cnt),
    .latch_en (ar_hs && ar_off == OFF_INSTRET_LO),
    .snap_en  (snap_en),
    .hi_out   (ins_hi)
  );

  // Misaligned and out-of-range offsets all land in default.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    unique case (ar_off)
      OFF_CYCLE_LO:   rd_data = cycle_cnt[31:0];
      OFF_CYCLE_HI:   rd_data = cyc_hi;
      OFF_INSTRET_LO: rd_data = instret_cnt[31:0];
      OFF_INSTRET_HI: rd_data = ins_hi;
      OFF_CTRL:       rd_data = {31'b0, snap_en};
      default:        rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rs_nxt = rs;
    unique case (rs)
      R_IDLE:  if (ar_hs) rs_nxt = R_RESP;
      R_RESP:  if (bus.RREADY) rs_nxt = R_IDLE;
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rs      <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rs <= rs_nxt;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  logic       aw_got, w_got;
  logic [4:0] awoff_q;
  logic       wbit_q, wstb_q;
  logic       aw_hs, w_hs;
  logic       aw_now, w_now;
  logic [4:0] wr_off;
  logic       wr_bit, wr_stb;
  logic       wr_fire, wr_ok;
  logic [1:0] bresp_q;

  assign bus.AWREADY = (ws == W_IDLE) && !aw_got;
  assign bus.WREADY  = (ws == W_IDLE) && !w_got;
  assign bus.BVALID  = (ws == W_RESP);
  assign bus.BRESP   = bresp_q;

  assign aw_hs   = bus.AWVALID && bus.AWREADY;
  assign w_hs    = bus.WVALID && bus.WREADY;
  assign aw_now  = aw_got || aw_hs;
  assign w_now   = w_got || w_hs;
  assign wr_off  = aw_hs ? awaddr[4:0] : awoff_q;
  assign wr_bit  = w_hs ? bus.WDATA[0] : wbit_q;
  assign wr_stb  = w_hs ? bus.WSTRB[0] : wstb_q;
  assign wr_fire = (ws == W_IDLE) && aw_now && w_now;
  assign wr_ok   = (wr_off == OFF_CTRL);

  always_comb begin
    ws_nxt = ws;
    unique case (ws)
      W_IDLE:  if (wr_fire) ws_nxt = W_RESP;
      W_RESP:  if (bus.BREADY) ws_nxt = W_IDLE;
      default: ws_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ws      <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      awoff_q <= '0;
      wbit_q  <= 1'b0;
      wstb_q  <= 1'b0;
      bresp_q <= RESP_OKAY;
      snap_en <= CTRL_RST;
    end else begin
      ws <= ws_nxt;
      if (wr_fire) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok && wr_stb)
          snap_en <= wr_bit;
      end else begin
        if (aw_hs) begin
          aw_got  <= 1'b1;
          awoff_q <= awaddr[4:0];
        end
        if (w_hs) begin
          w_got  <= 1'b1;
          wbit_q <= bus.WDATA[0];
          wstb_q <= bus.WSTRB[0];
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, araddr[ADDR_W-1:5],
                         awaddr[ADDR_W-1:5],
                         bus.WDATA[31:1], bus.WSTRB[3:1]};

endmodule

// File: tb/tb_csr_counter_axil_reader.sv
// Directed bench for csr_counter_axil_reader:
// coherent snapshots, SNAP_EN control, errors, handshakes, reset.
module tb_csr_counter_axil_reader;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [63:0] cycle_cnt = '0;
  logic [63:0] instret_cnt = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  csr_counter_axil_reader_if #(.ADDR_W(32)) bus ();

  csr_counter_axil_reader #(.ADDR_W(32), .CTRL_RST(1'b1)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
    .bus         (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // AR handshake only; response is left pending.
  task automatic ar_only(input logic [31:0] addr);
    bit done = 0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      logic rdy;
      rdy = bus.ARREADY;
      @(posedge CLK);
      done = rdy;
      @(negedge CLK);
    end
    bus.ARVALID = 1'b0;
    if (!done) chk("ar_timeout", 64'(done), 64'd1);
  endtask

  task automatic r_take(output logic [31:0] data,
                        output logic [1:0] resp);
    bit seen = 0;
    data = '0;
    resp = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.RVALID) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) begin
      chk("r_timeout", 64'(seen), 64'd1);
    end else begin
      data = bus.RDATA;
      resp = bus.RRESP;
      bus.RREADY = 1'b1;
      @(negedge CLK);
      bus.RREADY = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] addr,
                    output logic [31:0] data,
                    output logic [1:0] resp);
    ar_only(addr);
    r_take(data, resp);
  endtask

  task automatic b_take(output logic [1:0] resp);
    bit seen = 0;
    resp = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.BVALID) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) begin
      chk("b_timeout", 64'(seen), 64'd1);
    end else begin
      resp = bus.BRESP;
      bus.BREADY = 1'b1;
      @(negedge CLK);
      bus.BREADY = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, output logic [1:0] resp);
    bit aw_d = 0;
    bit w_d = 0;
    bus.AWADDR  = addr;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    for (int i = 0; i < 20 && !(aw_d && w_d); i++) begin
      logic aw_r, w_r;
      aw_r = bus.AWREADY;
      w_r  = bus.WREADY;
      @(posedge CLK);
      if (bus.AWVALID && aw_r) aw_d = 1;
      if (bus.WVALID && w_r) w_d = 1;
      @(negedge CLK);
      if (aw_d) bus.AWVALID = 1'b0;
      if (w_d) bus.WVALID = 1'b0;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    if (!(aw_d && w_d)) chk("aw_w_timeout", 64'(aw_d && w_d), 64'd1);
    b_take(resp);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [31:0] held;
  int          bcount;

  initial begin
    bus.ARADDR  = '0; bus.ARVALID = 0; bus.RREADY = 0;
    bus.AWADDR  = '0; bus.AWVALID = 0;
    bus.WDATA   = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;

    repeat (3) @(negedge CLK);
    chk("rst_arready", 64'(bus.ARREADY), 64'd1);
    chk("rst_awready", 64'(bus.AWREADY), 64'd1);
    chk("rst_wready",  64'(bus.WREADY),  64'd1);
    chk("rst_rvalid",  64'(bus.RVALID),  64'd0);
    chk("rst_bvalid",  64'(bus.BVALID),  64'd0);
    chk("rst_rdata",   64'(bus.RDATA),   64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    rd(32'h10, d, r);
    chk("rst_ctrl", 64'(d), 64'h1);
    chk("rst_ctrl_resp", 64'(r), 64'h0);

    // coherent sample across a LO->HI carry
    cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    rd(32'h00, d, r);
    chk("coh_lo", 64'(d), 64'hFFFF_FFFF);
    cycle_cnt = cycle_cnt + 64'd5;
    rd(32'h04, d, r);
    chk("coh_hi", 64'(d), 64'h1);
    rd(32'h04, d, r);
    chk("coh_hi_again", 64'(d), 64'h1);

    // upper address bits ignored
    rd(32'h8000_0010, d, r);
    chk("hi_addr_ctrl", 64'(d), 64'h1);

    wr(32'h10, 32'h0, 4'hF, r);
    chk("ctrl_wr0_resp", 64'(r), 64'h0);
    rd(32'h10, d, r);
    chk("ctrl_is0", 64'(d), 64'h0);
    cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    rd(32'h00, d, r);
    chk("live_lo", 64'(d), 64'hFFFF_FFFF);
    cycle_cnt = 64'h0000_0002_0000_0004;
    rd(32'h04, d, r);
    chk("live_hi", 64'(d), 64'h2);

    wr(32'h10, 32'h1, 4'hE, r);
    chk("nostrb_resp", 64'(r), 64'h0);
    rd(32'h10, d, r);
    chk("nostrb_ctrl", 64'(d), 64'h0);

    rd(32'h14, d, r);
    chk("oor_resp", 64'(r), 64'h2);
    chk("oor_data", 64'(d), 64'h0);
    instret_cnt = 64'hAAAA_BBBB_1234_5678;
    wr(32'h08, 32'hDEAD_BEEF, 4'hF, r);
    chk("ro_wr_resp", 64'(r), 64'h2);
    rd(32'h08, d, r);
    chk("ins_lo", 64'(d), 64'h1234_5678);
    chk("ins_lo_resp", 64'(r), 64'h0);
    rd(32'h02, d, r);
    chk("misal_resp", 64'(r), 64'h2);
    chk("misal_data", 64'(d), 64'h0);
    wr(32'h12, 32'h1, 4'hF, r);
    chk("misal_wr_resp", 64'(r), 64'h2);

    // W beat three cycles before AW
    bus.WDATA = 32'h1; bus.WSTRB = 4'h1; bus.WVALID = 1'b1;
    @(negedge CLK);
    bus.WVALID = 1'b0;
    chk("w_first_wready", 64'(bus.WREADY), 64'd0);
    bcount = 0;
    repeat (3) begin
      @(negedge CLK);
      bcount += int'(bus.BVALID);
    end
    chk("w_first_nob", 64'(bcount), 64'd0);
    bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
    @(negedge CLK);
    bus.AWVALID = 1'b0;
    bcount = 0;
    for (int i = 0; i < 6; i++) begin
      bcount += int'(bus.BVALID);
      bus.BREADY = bus.BVALID;
      @(negedge CLK);
      bus.BREADY = 1'b0;
    end
    chk("w_first_bcount", 64'(bcount), 64'd1);
    rd(32'h10, d, r);
    chk("ctrl_is1", 64'(d), 64'h1);

    // error read must not latch the shadow
    rd(32'h08, d, r);
    instret_cnt = 64'hCCCC_DDDD_0000_0000;
    rd(32'h0C, d, r);
    chk("ins_hi_snap", 64'(d), 64'hAAAA_BBBB);
    rd(32'h09, d, r);
    rd(32'h0C, d, r);
    chk("ins_hi_nolatch", 64'(d), 64'hAAAA_BBBB);

    cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    rd(32'h00, d, r);
    chk("wrap_lo", 64'(d), 64'hFFFF_FFFF);
    cycle_cnt = 64'h0;
    rd(32'h04, d, r);
    chk("wrap_hi", 64'(d), 64'hFFFF_FFFF);

    // RREADY held low four cycles
    ar_only(32'h10);
    held = bus.RDATA;
    chk("stall_first", 64'(held), 64'h1);
    bcount = 0;
    repeat (4) begin
      @(negedge CLK);
      if (bus.RDATA !== 32'h1 || bus.ARREADY !== 1'b0 ||
          bus.RVALID !== 1'b1) bcount++;
    end
    chk("stall_stable", 64'(bcount), 64'd0);
    r_take(d, r);
    chk("stall_data", 64'(d), 64'h1);
    @(negedge CLK);
    chk("stall_done_ar", 64'(bus.ARREADY), 64'd1);

    // reset while RVALID is high
    cycle_cnt = 64'h0000_0007_0000_0001;
    ar_only(32'h00);
    chk("mid_rvalid", 64'(bus.RVALID), 64'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(bus.RVALID), 64'd0);
    chk("mid_rst_ar", 64'(bus.ARREADY), 64'd1);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    rd(32'h04, d, r);
    chk("mid_shadow0", 64'(d), 64'h0);
    rd(32'h00, d, r);
    chk("mid_lo", 64'(d), 64'h1);
    rd(32'h04, d, r);
    chk("mid_hi", 64'(d), 64'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
